sdram_line_cache_dm: RTL and testbench
======================================

Name: sdram_line_cache_dm

Overview:
Direct-mapped, multi-line, read-only cache between a core read port and an SDRAM burst-read channel. It generalises a single-line cache to NUM_LINES lines and parametrised data/address widths. It adds a request/acknowledge handshake on both sides and a flush input. It sits in front of the SDRAM controller on ROM/graphics fetch paths.

Parameters:
ADDR_W, 25, word address width on both ports
DATA_W, 16, data word width
LINE_WORDS, 64, words per line; power of two, at least 2
NUM_LINES, 4, number of lines; power of two, at least 1

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
core_rd  in  1  read request; sampled only when core_busy=0
core_addr  in  ADDR_W  word address; sampled with core_rd
core_dout  out  DATA_W  read data; valid only while core_ack=1
core_ack  out  1  one-cycle pulse, exactly one per accepted core_rd
core_busy  out  1  high from acceptance of a miss until its core_ack
flush  in  1  invalidate all lines
sdram_req  out  1  burst request; held high until sdram_ack
sdram_addr  out  ADDR_W  line base address (offset bits 0); stable while sdram_req=1
sdram_ack  in  1  controller has accepted the burst
sdram_valid  in  1  one burst word present on sdram_dout
sdram_dout  in  DATA_W  burst data; words arrive in order, offsets 0..LINE_WORDS-1

Behaviour:
- Address split. OFF=log2(LINE_WORDS) and IDX=log2(NUM_LINES).
  - offset = addr[OFF-1:0]
  - index = addr[OFF+IDX-1:OFF] (no index field when NUM_LINES=1)
  - tag = the remaining upper bits
- Storage:
  - data RAM of NUM_LINES*LINE_WORDS words, read through a registered port
  - tag[] and valid[] arrays, one entry per line
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all valid bits=0
  - sdram_req=0, core_ack=0, core_busy=0, core_dout=0, fill counter=0
  - takes effect mid-fill: the burst is abandoned, and no core_ack is issued for it
- States: IDLE, REQ, FILL, RESP.
- IDLE:
  - core_rd=1 latches the address.
  - Hit (valid[index] and tag match): core_ack=1 with data on the next cycle; stay IDLE. Hit latency is 1 cycle, so back-to-back hits give one ack per cycle.
  - Miss: go to REQ and set core_busy=1 on the next cycle.
- REQ:
  - sdram_req=1, sdram_addr = latched address with offset bits zeroed.
  - On sdram_ack=1 go to FILL; sdram_req drops the next cycle.
  - In the same cycle tag[index] is written with the new tag and valid[index] is cleared.
- FILL:
  - Each sdram_valid=1 writes sdram_dout to line[index][count], then count increments.
  - The word whose count equals the latched offset is also captured into a hold register.
  - On the word with count=LINE_WORDS-1: valid[index]=1 unless the fill is tainted; go to RESP.
  - sdram_valid outside FILL is ignored.
- RESP:
  - core_ack=1 and core_dout=hold register for one cycle; core_busy=0 in the same cycle; go to IDLE.
  - Miss latency = cycles to sdram_ack + burst cycles + 2.
- core_rd while core_busy=1 is ignored; the core must hold or reissue it.
- Flush:
  - In IDLE or RESP, flush=1 clears all valid bits on the next edge. A simultaneous core_rd is evaluated as a miss.
  - In REQ or FILL, flush clears all valid bits and taints the fill. The burst still completes and the core still gets its word, but valid[index] stays 0.
- Simultaneous flush and core_rd hit in IDLE: flush wins; the access is a miss.
- sdram_addr is 0 whenever sdram_req=0.
- core_dout is 0 whenever core_ack=0.

Test Plan:
1. Reset, then core_rd at addr 0x000045 → sdram_req with sdram_addr=0x000040. Ack after 3 cycles, then 64 words with value=offset → core_ack with core_dout=0x0005. Then valid[1]=1.
2. After test 1, core_rd at 0x000041 then 0x00007F on consecutive cycles → two core_acks on consecutive cycles with 0x0001 and 0x003F; no sdram_req.
3. Conflict eviction: after test 1, read 0x000140 (same index, different tag) → refill with a burst of value 0xA000+offset, core_dout=0xA000. A following read of 0x000045 misses again.
4. Flush asserted mid-FILL at word 10 → burst completes and core_ack is delivered. A repeat read of the same address misses (new sdram_req).
5. rst_n pulled low at FILL word 20 → outputs go to reset values immediately. After release, a read of the same address misses.
6. Gapped burst: sdram_valid deasserted on random cycles → all 64 words are stored in order, and later hits return offset-correct data.

Source files
------------

// File: rtl/sdram_line_cache_dm_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_line_cache_dm_if
// Purpose  : Core read port and SDRAM burst-read channel of the direct-mapped
//            line cache, bundled as one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_line_cache_dm_if #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
);
   // core read port
   logic              core_rd;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_dout;
   logic              core_ack;
   logic              core_busy;
   logic              flush;
   // SDRAM burst-read channel
   logic              sdram_req;
   logic [ADDR_W-1:0] sdram_addr;
   logic              sdram_ack;
   logic              sdram_valid;
   logic [DATA_W-1:0] sdram_dout;

   // environment side: the core and the SDRAM controller
   modport master (
      output core_rd, core_addr, flush, sdram_ack, sdram_valid, sdram_dout,
      input  core_dout, core_ack, core_busy, sdram_req, sdram_addr
   );

   // cache side
   modport slave (
      input  core_rd, core_addr, flush, sdram_ack, sdram_valid, sdram_dout,
      output core_dout, core_ack, core_busy, sdram_req, sdram_addr
   );
endinterface
`default_nettype wire

// File: rtl/sdram_line_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : sdram_line_cache_dm
// Purpose  : Direct-mapped, read-only, multi-line cache between a core read
//            port and an SDRAM burst-read channel, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_line_cache_dm #(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int LINE_WORDS = 64,
   parameter int NUM_LINES  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   sdram_line_cache_dm_if.slave   bus
);

   localparam int c_OFF_W  = $clog2(LINE_WORDS);
   localparam int c_IDX_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 0;
   localparam int c_IW     = (c_IDX_W > 0) ? c_IDX_W : 1;
   localparam int c_TAG_W  = ADDR_W - c_OFF_W - c_IDX_W;
   localparam int c_RAM_AW = c_OFF_W + c_IDX_W;
   localparam int c_DEPTH  = NUM_LINES * LINE_WORDS;
   localparam logic [c_OFF_W-1:0] c_LAST = c_OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FILL = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;        // latched miss address
   logic [NUM_LINES-1:0] r_valid;
   logic [c_TAG_W-1:0]  r_tag [NUM_LINES];
   logic [DATA_W-1:0]   r_ram [c_DEPTH];
   logic [DATA_W-1:0]   r_rdata;       // registered RAM read port (hit path)
   logic [DATA_W-1:0]   r_hold;        // requested word captured during a fill
   logic [c_OFF_W-1:0]  r_cnt;         // fill word counter
   logic                r_taint;       // a flush hit this fill; do not validate it
   logic                r_src_hit;     // current ack returns RAM data, not r_hold
   logic                r_ack;
   logic                r_busy;
   logic                r_req;
   logic [ADDR_W-1:0]   r_sdram_addr;

   logic [c_OFF_W-1:0]  w_in_off;
   logic [c_OFF_W-1:0]  w_lat_off;
   logic [c_TAG_W-1:0]  w_in_tag;
   logic [c_TAG_W-1:0]  w_lat_tag;
   logic [c_IW-1:0]     w_in_idx;
   logic [c_IW-1:0]     w_lat_idx;
   logic [c_RAM_AW-1:0] w_raddr;
   logic [c_RAM_AW-1:0] w_waddr;
   logic                w_hit;

   assign w_in_off  = bus.core_addr[c_OFF_W-1:0];
   assign w_lat_off = r_addr[c_OFF_W-1:0];
   assign w_in_tag  = bus.core_addr[ADDR_W-1:c_OFF_W+c_IDX_W];
   assign w_lat_tag = r_addr[ADDR_W-1:c_OFF_W+c_IDX_W];

   // A single-line cache has no index field; line 0 is used throughout.
   generate
      if (c_IDX_W > 0) begin : g_idx
         assign w_in_idx  = bus.core_addr[c_OFF_W+c_IDX_W-1:c_OFF_W];
         assign w_lat_idx = r_addr[c_OFF_W+c_IDX_W-1:c_OFF_W];
         assign w_raddr   = {w_in_idx, w_in_off};
         assign w_waddr   = {w_lat_idx, r_cnt};
      end else begin : g_no_idx
         assign w_in_idx  = 1'b0;
         assign w_lat_idx = 1'b0;
         assign w_raddr   = w_in_off;
         assign w_waddr   = r_cnt;
      end
   endgenerate

   // A concurrent flush forces the access to be treated as a miss.
   assign w_hit = bus.core_rd && !bus.flush && r_valid[w_in_idx] &&
                  (r_tag[w_in_idx] == w_in_tag);

   // Line storage: burst words written in FILL, registered read for hits
   always_ff @(posedge clk) begin
      if (r_state == ST_FILL && bus.sdram_valid) begin
         r_ram[w_waddr] <= bus.sdram_dout;
      end
      r_rdata <= r_ram[w_raddr];
   end

   // Tag array: the new tag is recorded when the controller accepts the burst
   always_ff @(posedge clk) begin
      if (r_state == ST_REQ && bus.sdram_ack) begin
         r_tag[w_lat_idx] <= w_lat_tag;
      end
   end

   // Cache control FSM with registered handshake outputs and valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_valid      <= '0;
         r_cnt        <= '0;
         r_hold       <= '0;
         r_taint      <= 1'b0;
         r_src_hit    <= 1'b0;
         r_ack        <= 1'b0;
         r_busy       <= 1'b0;
         r_req        <= 1'b0;
         r_sdram_addr <= '0;
      end else begin
         r_ack <= 1'b0;
         // flush clears every line in any state; line-specific updates below
         // take precedence for the line being filled
         if (bus.flush) begin
            r_valid <= '0;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.core_rd) begin
                  r_addr <= bus.core_addr;
                  if (w_hit) begin
                     r_ack     <= 1'b1;
                     r_src_hit <= 1'b1;
                  end else begin
                     r_state      <= ST_REQ;
                     r_busy       <= 1'b1;
                     r_req        <= 1'b1;
                     r_sdram_addr <= {bus.core_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
                     r_taint      <= 1'b0;
                  end
               end
            end
            ST_REQ: begin
               if (bus.flush) begin
                  r_taint <= 1'b1;
               end
               if (bus.sdram_ack) begin
                  r_state            <= ST_FILL;
                  r_req              <= 1'b0;
                  r_sdram_addr       <= '0;
                  r_valid[w_lat_idx] <= 1'b0;
                  r_cnt              <= '0;
               end
            end
            ST_FILL: begin
               if (bus.flush) begin
                  r_taint <= 1'b1;
               end
               if (bus.sdram_valid) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == w_lat_off) begin
                     r_hold <= bus.sdram_dout;
                  end
                  if (r_cnt == c_LAST) begin
                     r_state <= ST_RESP;
                     if (!r_taint && !bus.flush) begin
                        r_valid[w_lat_idx] <= 1'b1;
                     end
                  end
               end
            end
            ST_RESP: begin
               r_state   <= ST_IDLE;
               r_ack     <= 1'b1;
               r_busy    <= 1'b0;
               r_src_hit <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.core_ack   = r_ack;
   assign bus.core_busy  = r_busy;
   assign bus.sdram_req  = r_req;
   assign bus.sdram_addr = r_sdram_addr;
   assign bus.core_dout  = r_ack ? (r_src_hit ? r_rdata : r_hold) : '0;

endmodule
`default_nettype wire

// File: tb/tb_sdram_line_cache_dm.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_line_cache_dm
// Purpose  : Scoreboard testbench for sdram_line_cache_dm. A behavioural
//            model of memory contents and line residency predicts every
//            response; a separate monitor checks the DUT outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_line_cache_dm;

   localparam int ADDR_W = 25;
   localparam int DATA_W = 16;

   typedef struct {
      logic [DATA_W-1:0] data;
      bit                hit;
      int                cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   bit   burst_expected = 1'b0;
   exp_t exp_q[$];

   // residency model: which line base address each index currently holds
   bit                res_v [4];
   logic [ADDR_W-1:0] res_base [4];

   sdram_line_cache_dm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sdram_line_cache_dm #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(64), .NUM_LINES(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // SDRAM contents: fixed, so the cache must always return the memory word
   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] base;
      base = a & ~25'h3F;
      if (base == 25'h40)  return {10'd0, a[5:0]};
      if (base == 25'h140) return 16'hA000 + {10'd0, a[5:0]};
      return (a[15:0] * 16'h9E37) ^ 16'h5A5A;
   endfunction

   // Monitor: pops the scoreboard on every core_ack and checks idle values
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.core_ack) begin
               if (exp_q.size() == 0) begin
                  check("ack_without_request", 32'(bus.core_ack), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("core_dout", 32'(bus.core_dout), 32'(e.data));
                  if (e.hit) check("hit_latency", 32'(cyc), 32'(e.cyc + 1));
               end
            end else begin
               check("dout_zero_without_ack", 32'(bus.core_dout), 32'd0);
            end
            if (!bus.sdram_req) check("sdram_addr_zero_idle", 32'(bus.sdram_addr), 32'd0);
            else if (!burst_expected) check("unexpected_sdram_req", 32'(bus.sdram_req), 32'd0);
         end
      end
   end

   // Acts as the SDRAM controller for one burst, with optional flush/reset injection
   task automatic serve_burst(input logic [ADDR_W-1:0] base, input int ack_dly, input int gap,
                              input int flush_w, input int rst_w);
      int n;
      n = 0;
      while (!bus.sdram_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("sdram_req_raised", 32'(bus.sdram_req), 32'd1);
      if (!bus.sdram_req) return;
      check("sdram_addr_line_base", 32'(bus.sdram_addr), 32'(base));
      check("core_busy_on_miss", 32'(bus.core_busy), 32'd1);
      // stray burst words before the ack must be ignored
      for (int i = 0; i < ack_dly; i++) begin
         bus.sdram_valid = 1'($urandom_range(1));
         bus.sdram_dout  = 16'($urandom);
         @(negedge clk);
      end
      bus.sdram_valid = 1'b0;
      check("sdram_req_held", 32'(bus.sdram_req), 32'd1);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      check("sdram_req_dropped", 32'(bus.sdram_req), 32'd0);
      for (int w = 0; w < 64; w++) begin
         bus.sdram_valid = 1'b0;
         bus.flush       = 1'b0;
         while (gap > 0 && int'($urandom_range(99)) < gap) @(negedge clk);
         if (w == rst_w) begin
            rst_n = 1'b0;
            #1;
            check("reset_core_ack", 32'(bus.core_ack), 32'd0);
            check("reset_core_busy", 32'(bus.core_busy), 32'd0);
            check("reset_sdram_req", 32'(bus.sdram_req), 32'd0);
            check("reset_core_dout", 32'(bus.core_dout), 32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         bus.sdram_valid = 1'b1;
         bus.sdram_dout  = mem_word(base + 25'(w));
         bus.flush       = (w == flush_w);
         @(negedge clk);
      end
      bus.sdram_valid = 1'b0;
      bus.flush       = 1'b0;
   endtask

   // One core read: predict hit/miss from the residency model, queue the answer
   task automatic access(input logic [ADDR_W-1:0] a, input bit fl, input int ack_dly,
                         input int gap, input int flush_w, input int rst_w);
      int                n;
      int                idx;
      bit                hit;
      logic [ADDR_W-1:0] base;
      exp_t              e;
      idx  = int'(a[7:6]);
      base = a & ~25'h3F;
      n = 0;
      while (bus.core_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (bus.core_busy) check("busy_timeout", 32'(bus.core_busy), 32'd0);
      if (fl) foreach (res_v[i]) res_v[i] = 1'b0;
      hit    = res_v[idx] && (res_base[idx] == base);
      e.data = mem_word(a);
      e.hit  = hit;
      e.cyc  = cyc;
      exp_q.push_back(e);
      if (!hit) burst_expected = 1'b1;
      bus.core_rd   = 1'b1;
      bus.core_addr = a;
      bus.flush     = fl;
      @(negedge clk);
      bus.core_rd = 1'b0;
      bus.flush   = 1'b0;
      if (!hit) begin
         serve_burst(base, ack_dly, gap, flush_w, rst_w);
         burst_expected = 1'b0;
         if (rst_w >= 0) begin
            exp_q.delete();
            foreach (res_v[i]) res_v[i] = 1'b0;
         end else begin
            if (flush_w >= 0) begin
               foreach (res_v[i]) res_v[i] = 1'b0;
            end else begin
               res_v[idx]    = 1'b1;
               res_base[idx] = base;
            end
            n = 0;
            while (exp_q.size() > 0 && n < 20) begin
               @(negedge clk);
               n++;
            end
            if (exp_q.size() > 0) begin
               check("miss_ack_timeout", 32'(exp_q.size()), 32'd0);
               exp_q.delete();
            end
         end
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      bus.core_rd     = 1'b0;
      bus.core_addr   = '0;
      bus.flush       = 1'b0;
      bus.sdram_ack   = 1'b0;
      bus.sdram_valid = 1'b0;
      bus.sdram_dout  = '0;
      foreach (res_v[i]) res_v[i] = 1'b0;
      foreach (res_base[i]) res_base[i] = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_core_ack", 32'(bus.core_ack), 32'd0);
      check("rst_core_busy", 32'(bus.core_busy), 32'd0);
      check("rst_sdram_req", 32'(bus.sdram_req), 32'd0);
      check("rst_sdram_addr", 32'(bus.sdram_addr), 32'd0);
      check("rst_core_dout", 32'(bus.core_dout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // first miss, then back-to-back hits in the same line
      access(25'h045, 1'b0, 3, 0, -1, -1);
      access(25'h041, 1'b0, 0, 0, -1, -1);
      access(25'h07F, 1'b0, 0, 0, -1, -1);

      // conflict eviction on index 1
      access(25'h140, 1'b0, 2, 0, -1, -1);
      access(25'h045, 1'b0, 1, 0, -1, -1);

      // flush during the fill: word still delivered, line not kept
      access(25'h0C3, 1'b0, 1, 0, 10, -1);
      access(25'h0C3, 1'b0, 0, 0, -1, -1);

      // reset during the fill: burst abandoned, line not kept
      access(25'h105, 1'b0, 2, 0, -1, 20);
      access(25'h105, 1'b0, 0, 0, -1, -1);

      // gapped burst then hits across the line
      access(25'h1A7, 1'b0, 2, 40, -1, -1);
      access(25'h180, 1'b0, 0, 0, -1, -1);
      access(25'h1BF, 1'b0, 0, 0, -1, -1);
      access(25'h1A7, 1'b0, 0, 0, -1, -1);

      // flush together with a read that would otherwise hit
      access(25'h1A0, 1'b1, 1, 0, -1, -1);

      // randomized traffic over four tags per index
      for (int i = 0; i < 60; i++) begin
         access(25'($urandom_range(1023)), ($urandom_range(9) == 0),
                int'($urandom_range(4)), int'($urandom_range(30)), -1, -1);
      end

      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
